// File: rtl/usb_bus_master.sv
// usb_bus_master: host-side initiator for the two-byte serial register protocol.
// Sends optional page prefix, command and data bytes to a UART FIFO, caches the remote page, captures read replies.
module usb_bus_master #(
    parameter logic [15:0] TimeoutCycles = 16'd50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Request,
    input  logic        R_nW,
    input  logic [15:0] Address,
    input  logic [7:0]  WrData,
    input  logic        Flush,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [7:0]  RdData,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady,
    input  logic [7:0]  RxData,
    input  logic        RxValid
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PAGE_CMD  = 3'd1,
        ST_PAGE_DATA = 3'd2,
        ST_CMD       = 3'd3,
        ST_DATA      = 3'd4,
        ST_WAIT_RX   = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        rnw_r;
    logic [15:0] addr_r;
    logic [7:0]  wdata_r;
    logic        page_known_r;
    logic        page_known_s;
    logic [7:0]  cached_page_r;
    logic [7:0]  cached_page_s;
    logic [15:0] count_r;
    logic        tmo_hit_r;
    logic        tx_fire_s;
    logic        page_hit_s;
    logic        error_s;
    logic        cur_rnw_s;
    logic [15:0] cur_addr_s;
    logic [7:0]  cur_wdata_s;
    logic        busy_s;
    logic        done_s;
    logic        tx_valid_s;
    logic [7:0]  tx_data_s;
    logic [7:0]  rd_data_s;

    // Registers 7'h00 (page) and 7'h7F are reachable from every page.
    function automatic logic is_page_free(input logic [6:0] reg_addr);
        return (reg_addr == 7'h00) || (reg_addr == 7'h7F);
    endfunction

    assign tx_fire_s  = TxValid && TxReady;
    // A Flush arriving with the request invalidates the cache before the hit check.
    assign page_hit_s = page_known_r && !Flush && (Address[15:8] == cached_page_r);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and error decision.
    always_comb begin
        state_s = state_r;
        error_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!Request) begin
                    state_s = ST_IDLE;
                end else if (Address[7]) begin
                    state_s = ST_DONE;
                    error_s = 1'b1;
                end else if (is_page_free(Address[6:0]) || page_hit_s) begin
                    state_s = ST_CMD;
                end else begin
                    state_s = ST_PAGE_CMD;
                end
            end
            ST_PAGE_CMD:  state_s = tx_fire_s ? ST_PAGE_DATA : ST_PAGE_CMD;
            ST_PAGE_DATA: state_s = tx_fire_s ? ST_CMD : ST_PAGE_DATA;
            ST_CMD: begin
                if (!tx_fire_s) begin
                    state_s = ST_CMD;
                end else if (rnw_r) begin
                    state_s = ST_WAIT_RX;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_DATA:      state_s = tx_fire_s ? ST_DONE : ST_DATA;
            ST_WAIT_RX: begin
                if (RxValid) begin
                    state_s = ST_DONE;
                end else if (tmo_hit_r) begin
                    state_s = ST_DONE;
                    error_s = 1'b1;
                end else begin
                    state_s = ST_WAIT_RX;
                end
            end
            ST_DONE:      state_s = ST_IDLE;
            default: begin
                state_s = ST_IDLE;
                error_s = 1'b0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output lands in a register.
    always_comb begin
        cur_rnw_s   = (state_r == ST_IDLE) ? R_nW    : rnw_r;
        cur_addr_s  = (state_r == ST_IDLE) ? Address : addr_r;
        cur_wdata_s = (state_r == ST_IDLE) ? WrData  : wdata_r;
        busy_s      = (state_s != ST_IDLE);
        done_s      = (state_s == ST_DONE);
        tx_valid_s  = 1'b0;
        tx_data_s   = TxData;
        case (state_s)
            ST_PAGE_CMD: begin
                tx_valid_s = 1'b1;
                tx_data_s  = 8'h00;
            end
            ST_PAGE_DATA: begin
                tx_valid_s = 1'b1;
                tx_data_s  = cur_addr_s[15:8];
            end
            ST_CMD: begin
                tx_valid_s = 1'b1;
                tx_data_s  = {cur_rnw_s, cur_addr_s[6:0]};
            end
            ST_DATA: begin
                tx_valid_s = 1'b1;
                tx_data_s  = cur_wdata_s;
            end
            default: begin
                tx_valid_s = 1'b0;
                tx_data_s  = TxData;
            end
        endcase
    end

    // Page cache and read capture; a same-cycle cache load beats Flush.
    always_comb begin
        page_known_s  = Flush ? 1'b0 : page_known_r;
        cached_page_s = cached_page_r;
        rd_data_s     = RdData;
        if ((state_r == ST_PAGE_DATA) && tx_fire_s) begin
            page_known_s  = 1'b1;
            cached_page_s = addr_r[15:8];
        end else if ((state_r == ST_DATA) && tx_fire_s && (addr_r[6:0] == 7'h00)) begin
            page_known_s  = 1'b1;
            cached_page_s = wdata_r;
        end else if ((state_r == ST_WAIT_RX) && RxValid) begin
            rd_data_s = RxData;
            if (addr_r[6:0] == 7'h00) begin
                page_known_s  = 1'b1;
                cached_page_s = RxData;
            end else begin
                cached_page_s = cached_page_r;
            end
        end else if ((state_r == ST_WAIT_RX) && tmo_hit_r) begin
            page_known_s = 1'b0;
        end else begin
            cached_page_s = cached_page_r;
        end
    end

    // Request latch, page cache and response timeout counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rnw_r         <= 1'b0;
            addr_r        <= 16'h0000;
            wdata_r       <= 8'h00;
            page_known_r  <= 1'b0;
            cached_page_r <= 8'h00;
            count_r       <= 16'h0000;
            tmo_hit_r     <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && Request) begin
                rnw_r   <= R_nW;
                addr_r  <= Address;
                wdata_r <= WrData;
            end
            page_known_r  <= page_known_s;
            cached_page_r <= cached_page_s;
            // Compare is registered, so the terminal cycle is one after count hits TimeoutCycles-1.
            if ((state_s == ST_WAIT_RX) && (state_r != ST_WAIT_RX)) begin
                count_r   <= 16'h0000;
                tmo_hit_r <= 1'b0;
            end else if (state_r == ST_WAIT_RX) begin
                count_r   <= count_r + 16'd1;
                tmo_hit_r <= (count_r == (TimeoutCycles - 16'd1));
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Error   <= 1'b0;
            RdData  <= 8'h00;
            TxData  <= 8'h00;
            TxValid <= 1'b0;
        end else begin
            Busy    <= busy_s;
            Done    <= done_s;
            Error   <= error_s;
            RdData  <= rd_data_s;
            TxData  <= tx_data_s;
            TxValid <= tx_valid_s;
        end
    end

endmodule

// File: tb/tb_usb_bus_master.sv
// Directed self-checking bench for usb_bus_master with a 16-cycle read timeout.
module tb_usb_bus_master;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Request;
    logic        R_nW;
    logic [15:0] Address;
    logic [7:0]  WrData;
    logic        Flush;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [7:0]  RdData;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;
    logic [7:0]  RxData;
    logic        RxValid;

    int tests = 0;
    int fails = 0;
    logic [7:0] got_q[$];
    int done_cyc;
    logic done_err;

    usb_bus_master #(.TimeoutCycles(16'd16)) dut (
        .Clk(Clk), .Reset(Reset), .Request(Request), .R_nW(R_nW),
        .Address(Address), .WrData(WrData), .Flush(Flush),
        .Busy(Busy), .Done(Done), .Error(Error), .RdData(RdData),
        .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .RxData(RxData), .RxValid(RxValid)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected bytes packed first-byte-in-MSB.
    task automatic check_bytes(input string tag, input int n, input logic [31:0] exp);
        logic [7:0] g;
        check({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), {24'h0, g}, {24'h0, exp[31-8*i -: 8]});
        end
    endtask

    // Request presented in cycle 0; runs until Done, recording transferred bytes.
    task automatic run_txn(input string tag, input logic rnw, input logic [15:0] addr,
                           input logic [7:0] wd, input logic flush, input logic rand_rdy,
                           input int rx_delay, input logic [7:0] rx_byte);
        int cmd_cyc;
        logic prev_stall;
        logic [7:0] prev_data;
        got_q.delete();
        done_cyc   = -1;
        done_err   = 1'bx;
        cmd_cyc    = -1;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        Request = 1'b1; R_nW = rnw; Address = addr; WrData = wd; Flush = flush; TxReady = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            Request = 1'b0; Flush = 1'b0; RxValid = 1'b0;
            R_nW = ~rnw; Address = ~addr; WrData = ~wd;
            if (prev_stall) begin
                check({tag, "_stall_valid"}, 32'(TxValid), 32'(1'b1));
                check({tag, "_stall_data"}, {24'h0, TxData}, {24'h0, prev_data});
            end
            TxReady = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if ((cmd_cyc >= 0) && (rx_delay >= 0) && (n == cmd_cyc + rx_delay)) begin
                RxValid = 1'b1;
                RxData  = rx_byte;
            end
            if (TxValid && TxReady) begin
                got_q.push_back(TxData);
                if (rnw && (TxData == {1'b1, addr[6:0]})) cmd_cyc = n;
            end
            if (Done) begin
                done_cyc = n;
                done_err = Error;
                break;
            end
            prev_stall = TxValid && !TxReady;
            prev_data  = TxData;
        end
        check({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'(1'b1));
        TxReady = 1'b1;
        tick();
        check({tag, "_done_pulse"}, {30'h0, Done, Busy}, 32'h0);
    endtask

    initial begin
        Reset = 1'b1; Request = 1'b0; R_nW = 1'b0; Address = 16'h0000; WrData = 8'h00;
        Flush = 1'b0; TxReady = 1'b1; RxData = 8'h00; RxValid = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        tick();
        check("reset_outs", {Busy, Done, Error, TxValid, RdData, TxData}, 32'h0);

        // Uncached write: page prefix then command and data.
        run_txn("w_0312", 1'b0, 16'h0312, 8'h5A, 1'b0, 1'b0, -1, 8'h00);
        check_bytes("w_0312", 4, 32'h0003125A);
        check("w_0312_cyc", done_cyc, 5);
        check("w_0312_err", 32'(done_err), 32'(1'b0));

        // Cached page hit.
        run_txn("w_0313", 1'b0, 16'h0313, 8'h11, 1'b0, 1'b0, -1, 8'h00);
        check_bytes("w_0313", 2, 32'h13110000);
        check("w_0313_cyc", done_cyc, 5 - 2);

        // Flush pulse in idle, then the prefix returns.
        Flush = 1'b1; tick(); Flush = 1'b0;
        run_txn("w_0313f", 1'b0, 16'h0313, 8'h11, 1'b0, 1'b0, -1, 8'h00);
        check_bytes("w_0313f", 4, 32'h00031311);
        check("w_0313f_cyc", done_cyc, 5);

        // Stray byte while idle is dropped.
        RxData = 8'h77; RxValid = 1'b1; tick(); RxValid = 1'b0;
        check("stray_rx", {23'h0, Busy, RdData}, 32'h0);

        // Read with reply three cycles after the command byte.
        run_txn("r_0320", 1'b1, 16'h0320, 8'h00, 1'b0, 1'b0, 3, 8'hC4);
        check_bytes("r_0320", 1, 32'hA0000000);
        check("r_0320_cyc", done_cyc, 5);
        check("r_0320_err", 32'(done_err), 32'(1'b0));
        check("r_0320_data", {24'h0, RdData}, 32'h000000C4);

        // Timeout: WAIT_RX entered in cycle 2, Done 17 cycles later.
        run_txn("r_tmo", 1'b1, 16'h0321, 8'h00, 1'b0, 1'b0, -1, 8'h00);
        check_bytes("r_tmo", 1, 32'hA1000000);
        check("r_tmo_cyc", done_cyc, 19);
        check("r_tmo_err", 32'(done_err), 32'(1'b1));
        check("r_tmo_hold", {24'h0, RdData}, 32'h000000C4);

        run_txn("w_0314", 1'b0, 16'h0314, 8'h22, 1'b0, 1'b0, -1, 8'h00);
        check_bytes("w_0314", 4, 32'h00031422);

        // Illegal address: immediate error, no bytes.
        run_txn("bad", 1'b0, 16'h0080, 8'h33, 1'b0, 1'b0, -1, 8'h00);
        check("bad_bytes", got_q.size(), 0);
        check("bad_cyc", done_cyc, 1);
        check("bad_err", 32'(done_err), 32'(1'b1));

        // Page-independent register: no prefix.
        run_txn("r_057F", 1'b1, 16'h057F, 8'h00, 1'b0, 1'b0, 2, 8'h3C);
        check_bytes("r_057F", 1, 32'hFF000000);
        check("r_057F_cyc", done_cyc, 4);
        check("r_057F_data", {24'h0, RdData}, 32'h0000003C);

        // Flush with the accepting Request forces the prefix.
        run_txn("w_0315f", 1'b0, 16'h0315, 8'h5C, 1'b1, 1'b0, -1, 8'h00);
        check_bytes("w_0315f", 4, 32'h0003155C);
        check("w_0315f_cyc", done_cyc, 5);

        // Random back-pressure.
        run_txn("w_rand", 1'b0, 16'h0745, 8'h9E, 1'b0, 1'b1, -1, 8'h00);
        check_bytes("w_rand", 4, 32'h0007459E);
        check("w_rand_err", 32'(done_err), 32'(1'b0));

        // Writing the page register loads the cache.
        run_txn("w_page", 1'b0, 16'h0000, 8'h06, 1'b0, 1'b0, -1, 8'h00);
        check_bytes("w_page", 2, 32'h00060000);
        check("w_page_cyc", done_cyc, 3);
        run_txn("w_0601", 1'b0, 16'h0601, 8'hAB, 1'b0, 1'b0, -1, 8'h00);
        check_bytes("w_0601", 2, 32'h01AB0000);

        // Reset mid-byte drops TxValid and Busy asynchronously.
        TxReady = 1'b0; Request = 1'b1; R_nW = 1'b0; Address = 16'h0901; WrData = 8'h44;
        tick();
        Request = 1'b0;
        tick();
        check("stall_busy", {30'h0, Busy, TxValid}, 32'h3);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst", {29'h0, Busy, TxValid, Done}, 32'h0);
        tick();
        Reset = 1'b0;
        TxReady = 1'b1;
        tick();
        check("post_rst", {29'h0, Busy, TxValid, Done}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
